// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types and constants for the seven-segment scan controller
package led_pkg;
  typedef logic [4:0] dig_t;

  localparam int         N_DIG     = 8;
  localparam logic [7:0] CS_OFF    = 8'hFF;
  localparam dig_t       DIG_BLANK = 5'h00;

  // Active-low one-hot digit select for a pointer value
  function automatic logic [N_DIG-1:0] cs_sel(input logic [2:0] ptr);
    return ~(N_DIG'(1) << ptr);
  endfunction
endpackage

// File: rtl/led_rr_arb.sv
// rtl/led_rr_arb.sv - 2-way round-robin arbiter, priority flips to the other side after each grant
module led_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;  // set: requester 1 wins a tie

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    prio <= 1'b0;
    else if (|req) prio <= gnt[0];
  end
endmodule

// File: rtl/led_scan_arbiter.sv
// rtl/led_scan_arbiter.sv - 8-digit frame buffer with RR write port and multiplexed scan
// Optional anti-ghost blanking at the start of each slot: LED_SCAN_BLANK_EN
module led_scan_arbiter
  import led_pkg::*;
#(
  parameter int F_CLK     = 50000000,
  parameter int F_SCAN    = 1000,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] wr_valid,
  input  logic [2:0] wr_addr0,
  input  logic [2:0] wr_addr1,
  input  dig_t       wr_data0,
  input  dig_t       wr_data1,
  output logic [1:0] wr_ready,
  output logic [7:0] cs,
  output dig_t       dig_ctrl,
  output logic       frame_sync
);
  localparam int DIV = F_CLK / F_SCAN;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_chk
    $error("led_scan_arbiter: slot length DIV=%0d must be >= 2 (BLANK_CYC=%0d)", DIV, BLANK_CYC);
  end
`ifdef LED_SCAN_BLANK_EN
  if (BLANK_CYC >= DIV) begin : g_blank_chk
    $error("led_scan_arbiter: BLANK_CYC=%0d must be < DIV=%0d", BLANK_CYC, DIV);
  end
`endif

  logic [1:0]    gnt;
  dig_t          fbuf [N_DIG];
  logic [CW-1:0] cnt;
  logic [2:0]    ptr;
  logic          slot_end;

  led_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_valid),
    .gnt   (gnt)
  );

  // Grants are suppressed during reset so no write can be in flight across it
  assign wr_ready = rst_n ? gnt : 2'b00;
  assign slot_end = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIG; i++) fbuf[i] <= DIG_BLANK;
    end else if (wr_valid[0] && wr_ready[0]) begin
      fbuf[wr_addr0] <= wr_data0;
    end else if (wr_valid[1] && wr_ready[1]) begin
      fbuf[wr_addr1] <= wr_data1;
    end
  end

  // Outputs sample the pre-edge pointer and buffer, so a write shows one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      ptr        <= 3'd0;
      cs         <= CS_OFF;
      dig_ctrl   <= DIG_BLANK;
      frame_sync <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) ptr <= ptr + 3'd1;
      frame_sync <= slot_end && (ptr == 3'd7);
`ifdef LED_SCAN_BLANK_EN
      if (cnt < CW'(BLANK_CYC)) begin
        cs <= CS_OFF;
      end else begin
        cs       <= cs_sel(ptr);
        dig_ctrl <= fbuf[ptr];
      end
`else
      cs       <= cs_sel(ptr);
      dig_ctrl <= fbuf[ptr];
`endif
    end
  end
endmodule

// File: tb/tb_led_scan_arbiter.sv
// tb/tb_led_scan_arbiter.sv - directed table-driven bench for led_scan_arbiter (DIV=16, BLANK_CYC=4)
module tb_led_scan_arbiter;
  localparam int DIV   = 16;
  localparam int BLANK = 4;
  localparam int FRAME = 8 * DIV;

  typedef struct {
    logic [1:0] valid;
    logic [2:0] a0;
    logic [4:0] d0;
    logic [2:0] a1;
    logic [4:0] d1;
    logic [1:0] rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] wr_valid;
  logic [2:0] wr_addr0, wr_addr1;
  logic [4:0] wr_data0, wr_data1;
  logic [1:0] wr_ready;
  logic [7:0] cs;
  logic [4:0] dig_ctrl;
  logic       frame_sync;

  int checks = 0;
  int failures = 0;
  int e = 0;
  int ff_cnt = 0;
  int fs_cnt = 0;
  logic [4:0] mbuf [8];
  logic [4:0] exp_dig;
  logic       pw_en;
  logic [2:0] pw_addr;
  logic [4:0] pw_data;
  vec_t       tbl [12];

  led_scan_arbiter #(.F_CLK(16), .F_SCAN(1), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_data0   (wr_data0),
    .wr_data1   (wr_data1),
    .wr_ready   (wr_ready),
    .cs         (cs),
    .dig_ctrl   (dig_ctrl),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, e);
    end
  endtask

  // One clock with the model: expected outputs come from the pre-edge slot state
  task automatic tick();
    int         cnt_m, ptr_m;
    logic [7:0] one8, ecs;
    logic       efs;
    one8  = 8'h01;
    cnt_m = e % DIV;
    ptr_m = (e / DIV) % 8;
    ecs   = ~(one8 << ptr_m);
`ifdef LED_SCAN_BLANK_EN
    if (cnt_m < BLANK) ecs = 8'hFF;
    else               exp_dig = mbuf[ptr_m];
`else
    exp_dig = mbuf[ptr_m];
`endif
    efs = ((e % FRAME) == FRAME - 1);
    if (pw_en) mbuf[pw_addr] = pw_data;
    @(posedge clk);
    #1;
    e++;
    chk("cs", 32'(cs), 32'(ecs));
    chk("dig_ctrl", 32'(dig_ctrl), 32'(exp_dig));
    chk("frame_sync", 32'(frame_sync), 32'(efs));
    if (cs == 8'hFF) ff_cnt++;
    if (frame_sync) fs_cnt++;
  endtask

  task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [4:0] d0,
                       input logic [2:0] a1, input logic [4:0] d1);
    wr_valid = v; wr_addr0 = a0; wr_data0 = d0; wr_addr1 = a1; wr_data1 = d1;
  endtask

  initial begin
    tbl[0]  = '{2'b01, 3'd3, 5'h1A, 3'd0, 5'h00, 2'b01};
    tbl[1]  = '{2'b00, 3'd0, 5'h00, 3'd0, 5'h00, 2'b00};
    tbl[2]  = '{2'b10, 3'd0, 5'h00, 3'd7, 5'h17, 2'b10};
    tbl[3]  = '{2'b11, 3'd0, 5'h10, 3'd1, 5'h11, 2'b01};
    tbl[4]  = '{2'b11, 3'd2, 5'h12, 3'd1, 5'h11, 2'b10};
    tbl[5]  = '{2'b11, 3'd2, 5'h12, 3'd5, 5'h15, 2'b01};
    tbl[6]  = '{2'b11, 3'd6, 5'h1F, 3'd5, 5'h15, 2'b10};
    tbl[7]  = '{2'b01, 3'd6, 5'h1F, 3'd0, 5'h00, 2'b01};
    tbl[8]  = '{2'b00, 3'd0, 5'h00, 3'd0, 5'h00, 2'b00};
    tbl[9]  = '{2'b11, 3'd4, 5'h0C, 3'd4, 5'h1E, 2'b10};
    tbl[10] = '{2'b01, 3'd4, 5'h0C, 3'd0, 5'h00, 2'b01};
    tbl[11] = '{2'b00, 3'd0, 5'h00, 3'd0, 5'h00, 2'b00};

    for (int i = 0; i < 8; i++) mbuf[i] = 5'h00;
    exp_dig = 5'h00;
    pw_en = 1'b0; pw_addr = 3'd0; pw_data = 5'h00;

    // Reset with both requesters asking: no grant, outputs in reset state
    rst_n = 1'b0;
    drive(2'b11, 3'd1, 5'h01, 3'd2, 5'h02);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_wr_ready", 32'(wr_ready), 32'h0);
      chk("rst_cs", 32'(cs), 32'hFF);
      chk("rst_dig", 32'(dig_ctrl), 32'h00);
      chk("rst_fs", 32'(frame_sync), 32'h0);
    end

    // Idle scan for two frames
    rst_n = 1'b1;
    drive(2'b00, 3'd0, 5'h00, 3'd0, 5'h00);
    e = 0; ff_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    chk("fs_pulses", 32'(fs_cnt), 32'd2);
`ifdef LED_SCAN_BLANK_EN
    chk("blank_cycles", 32'(ff_cnt), 32'(2 * 8 * BLANK));
`else
    chk("blank_cycles", 32'(ff_cnt), 32'd0);
`endif

    // Arbitration table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("wr_ready[%0d]", i), 32'(wr_ready), 32'(tbl[i].rdy));
      pw_en   = |tbl[i].rdy;
      pw_addr = tbl[i].rdy[0] ? tbl[i].a0 : tbl[i].a1;
      pw_data = tbl[i].rdy[0] ? tbl[i].d0 : tbl[i].d1;
      tick();
      pw_en = 1'b0;
    end
    drive(2'b00, 3'd0, 5'h00, 3'd0, 5'h00);
    for (int i = 0; i < FRAME; i++) tick();

    // Write to the active digit mid-slot
    for (int i = 0; i < DIV && (e % DIV) != 8; i++) tick();
    begin
      int p;
      logic [4:0] oldv, newv;
      p = (e / DIV) % 8;
      oldv = mbuf[p];
      newv = oldv ^ 5'h15;
      drive(2'b01, 3'(p), newv, 3'd0, 5'h00);
      #1;
      chk("active_wr_ready", 32'(wr_ready), 32'h1);
      pw_en = 1'b1; pw_addr = 3'(p); pw_data = newv;
      tick();
      pw_en = 1'b0;
      drive(2'b00, 3'd0, 5'h00, 3'd0, 5'h00);
      chk("active_dig_old", 32'(dig_ctrl), 32'(oldv));
      tick();
      chk("active_dig_new", 32'(dig_ctrl), 32'(newv));
    end

    // Write to the next digit on the slot-change edge
    for (int i = 0; i < DIV && (e % DIV) != DIV - 1; i++) tick();
    begin
      int p;
      p = ((e / DIV) + 1) % 8;
      drive(2'b01, 3'(p), 5'h1D, 3'd0, 5'h00);
      #1;
      chk("wrap_wr_ready", 32'(wr_ready), 32'h1);
      pw_en = 1'b1; pw_addr = 3'(p); pw_data = 5'h1D;
      tick();
      pw_en = 1'b0;
      drive(2'b00, 3'd0, 5'h00, 3'd0, 5'h00);
      for (int i = 0; i < DIV; i++) tick();
    end

    // Reset at ptr=5 mid-slot with req1 pending
    for (int i = 0; i < FRAME && !(((e / DIV) % 8) == 5 && (e % DIV) == 6); i++) tick();
    chk("reached_ptr5", 32'((e / DIV) % 8), 32'd5);
    drive(2'b10, 3'd6, 5'h0A, 3'd2, 5'h1B);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_ready", 32'(wr_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_cs", 32'(cs), 32'hFF);
    chk("midrst_dig", 32'(dig_ctrl), 32'h00);
    chk("midrst_fs", 32'(frame_sync), 32'h0);
    for (int i = 0; i < 8; i++) mbuf[i] = 5'h00;
    exp_dig = 5'h00;
    e = 0;
    rst_n = 1'b1;
    drive(2'b11, 3'd6, 5'h0A, 3'd2, 5'h1B);
    #1;
    chk("post_rst_prio", 32'(wr_ready), 32'h1);
    pw_en = 1'b1; pw_addr = 3'd6; pw_data = 5'h0A;
    tick();
    drive(2'b10, 3'd6, 5'h0A, 3'd2, 5'h1B);
    #1;
    chk("post_rst_req1", 32'(wr_ready), 32'h2);
    pw_addr = 3'd2; pw_data = 5'h1B;
    tick();
    pw_en = 1'b0;
    drive(2'b00, 3'd0, 5'h00, 3'd0, 5'h00);
    for (int i = 0; i < FRAME; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
